// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage RV32 pipeline: load-use bubble, redirect flush,
// data-memory wait FSM with timeout halt. Define HAZARD_CTRL_PERF_EN to add perf counters.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_wen,
    input  logic        ex_is_load,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_flush,
`ifdef HAZARD_CTRL_PERF_EN
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count,
`endif
    output logic        mem_timeout
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic            mem_stall;
    logic            load_use;
    logic            redirect_eff;
    logic            load_use_eff;

    assign mem_stall = ((state_q == StRun) && mem_req && !mem_ready) ||
                       ((state_q == StMemWait) && !mem_ready);

    assign load_use = ex_is_load && ex_wen && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    assign redirect_eff = (state_q != StHalt) && !mem_stall && ex_redirect;
    assign load_use_eff = (state_q != StHalt) && !mem_stall && !ex_redirect && load_use;

    // Count of stalled cycles including the current one; halt once it reaches the limit.
    assign cnt_inc = (state_q == StRun) ? CntW'(1) : wait_cnt_q + CntW'(1);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StRun, StMemWait: begin
                if (mem_stall) begin
                    wait_cnt_d = cnt_inc;
                    state_d    = (cnt_inc >= TimeoutVal) ? StHalt : StMemWait;
                end else if (state_q == StMemWait) begin
                    wait_cnt_d = '0;
                    state_d    = StRun;
                end
            end
            StHalt: state_d = StHalt;
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (rst) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
            {if_id_flush, id_ex_flush, mem_wb_flush} = 3'b111;
        end else if (state_q == StHalt) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
        end else if (mem_stall) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
            mem_wb_flush = 1'b1;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    assign mem_timeout = (state_q == StHalt);

`ifdef HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else if (state_q != StHalt) begin
            if (mem_stall || load_use_eff) perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (redirect_eff)              perf_flush_count  <= perf_flush_count + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = redirect_eff ^ load_use_eff;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed test-plan scenarios then random stimulus,
// checked against a cycle-level behavioural model of the stall/flush rules.
module tb_hazard_ctrl;

    localparam int unsigned T = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_wen = 1'b0, ex_is_load = 1'b0;
    logic ex_redirect = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout;
`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

    hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_wen       (ex_wen),
        .ex_is_load   (ex_is_load),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .mem_wb_flush (mem_wb_flush),
`ifdef HAZARD_CTRL_PERF_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count),
`endif
        .mem_timeout  (mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  v;      // {en x4, if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout}
        logic        chk_to;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Behavioural model: halted flag, length of the current stalled run, perf totals
    bit          m_halted = 0;
    int unsigned m_run = 0;
    logic [31:0] m_ps = '0, m_pf = '0;

    task automatic step(input string nm, input logic r,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic wen, input logic ld, input logic redir,
                        input logic mreq, input logic mrdy);
        exp_t e;
        logic lu, stall;
        @(posedge clk); #1;
        rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_wen = wen; ex_is_load = ld; ex_redirect = redir;
        mem_req = mreq; mem_ready = mrdy;
        lu = ld && wen && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        stall = !mrdy && (mreq || m_run > 0);
        e.name = nm;
        e.chk_to = !r;
        e.ps = m_ps;
        e.pf = m_pf;
        if (r)             e.v = 8'b0000_1110;
        else if (m_halted) e.v = 8'b0000_0001;
        else if (stall)    e.v = 8'b0000_0010;
        else if (redir)    e.v = 8'b1111_1100;
        else if (lu)       e.v = 8'b0011_0100;
        else               e.v = 8'b1111_0000;
        exp_q.push_back(e);
        if (r) begin
            m_halted = 0; m_run = 0; m_ps = '0; m_pf = '0;
        end else if (!m_halted) begin
            if (stall) begin
                m_run++;
                m_ps++;
                if (m_run >= T) m_halted = 1;
            end else begin
                m_run = 0;
                if (redir)   m_pf++;
                else if (lu) m_ps++;
            end
        end
    endtask

    task automatic idle(input string nm, input int n);
        for (int i = 0; i < n; i++)
            step(nm, 0, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 1);
    endtask

    // Monitor: one scoreboard entry is consumed per cycle, sampled mid-cycle
    initial begin
        exp_t e;
        logic [7:0] act, mask;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {pc_en, if_id_en, id_ex_en, ex_mem_en,
                       if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout};
                mask = e.chk_to ? 8'hFF : 8'hFE;
                checks++;
                if (((act ^ e.v) & mask) != 8'h00) begin
                    errors++;
                    $display("FAIL %s t=%0t outputs got %b expected %b (mask %b)",
                             e.name, $time, act, e.v, mask);
                end
`ifdef HAZARD_CTRL_PERF_EN
                checks++;
                if (perf_stall_cycles != e.ps || perf_flush_count != e.pf) begin
                    errors++;
                    $display("FAIL %s_perf t=%0t got stall=%0d flush=%0d expected %0d %0d",
                             e.name, $time, perf_stall_cycles, perf_flush_count, e.ps, e.pf);
                end
`endif
            end
        end
    end

    initial begin
        int guard;
        step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("idle", 2);
        // load x5 in EX, ID reads rs2=x5: one bubble, then clear
        step("load_use", 0, 5'd1, 5'd5, 0, 1, 5'd5, 1, 1, 0, 0, 1);
        step("after_bubble", 0, 5'd1, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, 1);
        // x0 never hazards; non-load write does not bubble
        step("rd_x0", 0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 1);
        step("non_load", 0, 5'd1, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, 1);
        step("use_rs1", 0, 5'd7, 5'd1, 1, 0, 5'd7, 1, 1, 0, 0, 1);
        step("unused_src", 0, 5'd7, 5'd7, 0, 0, 5'd7, 1, 1, 0, 0, 1);
        // redirect wins over load_use
        step("redir_lu", 0, 5'd1, 5'd5, 0, 1, 5'd5, 1, 1, 1, 0, 1);
        // zero-wait access
        step("zero_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // 3 wait cycles, redirect pending during the wait acts only on ready cycle
        step("mem_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("mem_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("mem_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("mem_ready", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        idle("post_wait", 1);
        // timeout: ready never rises
        for (int i = 0; i < T + 3; i++)
            step("timeout", 0, 5'd1, 5'd5, 0, 1, 5'd5, 1, 1, 1, 1, 0);
        step("halt_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle("after_rst", 2);
        // random phase
        for (int i = 0; i < 3000; i++) begin
            logic r, u1, u2, wen, ld, redir, mreq, mrdy;
            logic [4:0] rs1, rs2, rd;
            r     = ($urandom_range(0, 99) < 3);
            rs1   = 5'($urandom_range(0, 3));
            rs2   = 5'($urandom_range(0, 3));
            rd    = 5'($urandom_range(0, 3));
            u1    = 1'($urandom);
            u2    = 1'($urandom);
            wen   = ($urandom_range(0, 3) != 0);
            ld    = 1'($urandom);
            redir = ($urandom_range(0, 5) == 0);
            mreq  = ($urandom_range(0, 2) == 0);
            mrdy  = ($urandom_range(0, 9) < 6);
            step("rand", r, rs1, rs2, u1, u2, rd, wen, ld, redir, mreq, mrdy);
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall sequencer for the 5-stage RV32 core. It compares the ID-stage source registers against the EX-stage destination, takes the EX-stage redirect (`pcSel` from the branch/jump decision) and the MEM-stage data-memory handshake, and drives the per-stage enable and flush strobes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It owns the data-memory wait FSM, including a bounded timeout that halts the pipeline.

## Interface
- `MEM_TIMEOUT`, 255: maximum consecutive stalled cycles on one memory access before halting; legal range 1..65535.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `id_rs1`, `id_rs2` in 5: source register indices of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: ID instruction actually reads rs1 / rs2.
- `ex_rd` in 5: destination register of the instruction in EX.
- `ex_wen` in 1: EX instruction writes `ex_rd`.
- `ex_is_load` in 1: EX instruction is a load.
- `ex_redirect` in 1: EX resolved a taken branch or jump (`pcSel`=1).
- `mem_req` in 1: MEM stage holds a load/store.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` out 1: register load enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush` out 1: insert a bubble (NOP) into that register.
- `mem_timeout` out 1: sticky halt flag.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Outputs are combinational from state and inputs. State and counter are registered.
- Conditions:
  - mem_stall = (RUN and `mem_req` and not `mem_ready`), or (MEM_WAIT and not `mem_ready`).
  - load_use = `ex_is_load` and `ex_wen` and `ex_rd`≠0 and ((`id_use_rs1` and `id_rs1`==`ex_rd`) or (`id_use_rs2` and `id_rs2`==`ex_rd`)).
- Priority order is mem_stall > redirect > load_use > normal.
- mem_stall:
  - All four enables are 0.
  - `mem_wb_flush`=1.
  - Other flushes are 0.
  - The redirect and load_use conditions are ignored. The EX instruction is held, so it re-presents them later.
- redirect (`ex_redirect`, no mem_stall):
  - All enables are 1.
  - `if_id_flush`=1 and `id_ex_flush`=1.
  - `mem_wb_flush`=0.
  - Any load_use in the same cycle is discarded, because the ID instruction is wrong-path.
- load_use only:
  - `pc_en`=0 and `if_id_en`=0.
  - `id_ex_en`=1 and `id_ex_flush`=1.
  - `ex_mem_en`=1.
  - Exactly one bubble. The next cycle the load is in MEM, so the condition clears.
- Normal: all enables are 1 and all flushes are 0.
- Transitions:
  - RUN→MEM_WAIT when `mem_req` and not `mem_ready`; `wait_cnt`←1.
  - MEM_WAIT→RUN when `mem_ready`. That cycle is not a stall, so the enables follow the lower-priority rules.
  - MEM_WAIT with not `mem_ready`: `wait_cnt`←`wait_cnt`+1. If `wait_cnt`==`MEM_TIMEOUT`, go to HALT instead.
  - HALT is left only by `rst`. In HALT all enables are 0, all flushes are 0 and `mem_timeout`=1.
- `wait_cnt` is $clog2(`MEM_TIMEOUT`+1) bits wide and never wraps.
- `ex_rd`==0 never creates a hazard.
- `mem_req` and `mem_ready` high in the same RUN cycle is a zero-wait access: no stall and no state change.

## Timing
- Reset (`rst`=1 at a `clk` edge):
  - State→RUN, `wait_cnt`→0, `mem_timeout`→0.
  - While `rst` is high, outputs are forced: all enables 0, all three flushes 1.
- Hazard outputs have zero-cycle latency from inputs. The stage registers sample them on the same edge.
- Memory access with N wait cycles (`mem_ready` low N cycles after `mem_req` appears) gives exactly N stalled cycles. The enables rise in the cycle `mem_ready` is high.
- Timeout: HALT is entered on the edge after the `MEM_TIMEOUT`-th consecutive stalled cycle. `mem_timeout` is high from the next cycle.
- `rst` asserted during MEM_WAIT or HALT aborts the wait. The MEM-stage access is dropped via `mem_wb_flush`.

## Configuration
- `HAZARD_CTRL_PERF_EN` defined: adds outputs `perf_stall_cycles` (32) and `perf_flush_count` (32).
  - `perf_stall_cycles` increments on each mem_stall or load_use cycle.
  - `perf_flush_count` increments on each redirect cycle.
  - Both reset to 0, wrap modulo 2^32 and are frozen in HALT.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Load x5 in EX, ID reads rs2=x5 with `id_use_rs2`=1 -> one cycle with `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1; next cycle all enables 1.
- Load with `ex_rd`=0 and ID reading x0 -> no stall; same for a non-load `ex_wen`=1 to x5.
- `ex_redirect`=1 coincident with load_use -> `if_id_flush`=1, `id_ex_flush`=1, `pc_en`=1, no bubble-hold.
- `mem_req`=1 with `mem_ready` low 3 cycles then high -> 3 cycles of all enables 0 and `mem_wb_flush`=1; then RUN. A redirect pending during the wait acts only on the ready cycle.
- `MEM_TIMEOUT`=4, `mem_ready` never rises -> HALT and `mem_timeout`=1 after 4 stalled cycles, held; `rst` pulse -> RUN, `mem_timeout`=0.
- With `HAZARD_CTRL_PERF_EN`: the two scenarios above give `perf_stall_cycles`=4 and `perf_flush_count`=1.
